// File: rtl/simo_unpack_fifo.sv
// Purpose: unpacks one precision-packed byte per write (1x8b, 2x4b or 4x2b) and pops up to DATA_LENGTH elements per pop.
// Latency: pop data is registered at the accepting edge; written elements become poppable one edge later.
// Backpressure: o_full rises when free slots < capacity of current i_p_mode; writes while full and pops while empty are ignored.
module simo_unpack_fifo #(
  parameter int DEPTH       = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int DATA_LENGTH = 8,
  parameter int ADDR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                                    i_clk,
  input  logic                                    i_nrst,
  input  logic                                    i_clear,
  input  logic                                    i_write_en,
  input  logic [1:0]                              i_p_mode,
  input  logic [DATA_WIDTH-1:0]                   i_data,
  input  logic [1:0]                              i_partial,
  input  logic                                    i_pop_en,
  output logic [DATA_LENGTH-1:0][DATA_WIDTH-1:0]  o_data,
  output logic [DATA_LENGTH-1:0]                  o_valid,
  output logic                                    o_pop_valid,
  output logic [ADDR_WIDTH:0]                     o_count,
  output logic                                    o_empty,
  output logic                                    o_full
);

  localparam int CW = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] w_ptr;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [CW-1:0]         count;

  logic [CW-1:0]         cap;
  logic [CW-1:0]         free_slots;
  logic [CW-1:0]         wr_n;
  logic [CW-1:0]         pop_m;
  logic                  wr_acc;
  logic                  pop_acc;
  logic [3:0][DATA_WIDTH-1:0]              sub_dat;
  logic [DATA_LENGTH-1:0][DATA_WIDTH-1:0]  pop_dat;
  logic [DATA_LENGTH-1:0]                  pop_vld;

  // Mode capacity, fullness against that capacity, and element counts moved this cycle.
  always_comb begin
    cap = CW'(1);
    case (i_p_mode)
      2'b01:   cap = CW'(2);
      2'b10:   cap = CW'(4);
      default: cap = CW'(1);
    endcase
    free_slots = CW'(DEPTH) - count;
    o_full     = (free_slots < cap);
    o_empty    = (count == '0);
    wr_acc     = i_write_en && !o_full;
    pop_acc    = i_pop_en && !o_empty;
    // Partial counts beyond the mode capacity saturate to a full word.
    if (i_partial == 2'd0 || CW'(i_partial) >= cap) wr_n = cap;
    else                                            wr_n = CW'(i_partial);
    pop_m = (count < CW'(DATA_LENGTH)) ? count : CW'(DATA_LENGTH);
  end

  // Split the packed byte into zero-extended subwords; slots above the mode capacity are never written.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      sub_dat[k] = '0;
      case (i_p_mode)
        2'b01:   sub_dat[k] = DATA_WIDTH'(i_data[(k % 2) * 4 +: 4]);
        2'b10:   sub_dat[k] = DATA_WIDTH'(i_data[k * 2 +: 2]);
        default: sub_dat[k] = i_data;
      endcase
    end
  end

  // Gather the oldest pop_m elements into lanes; the remaining lanes stay zero.
  always_comb begin
    pop_dat = '0;
    pop_vld = '0;
    for (int i = 0; i < DATA_LENGTH; i++) begin
      if (CW'(i) < pop_m) begin
        pop_dat[i] = mem[r_ptr + ADDR_WIDTH'(i)];
        pop_vld[i] = 1'b1;
      end
    end
  end

  // Element storage; contents survive reset and clear, only pointers say what is live.
  always_ff @(posedge i_clk) begin
    if (i_nrst && !i_clear && wr_acc) begin
      for (int k = 0; k < 4; k++) begin
        if (CW'(k) < wr_n) mem[w_ptr + ADDR_WIDTH'(k)] <= sub_dat[k];
      end
    end
  end

  // Pointers, occupancy and registered pop outputs; count uses pre-update values for both sides.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      w_ptr       <= '0;
      r_ptr       <= '0;
      count       <= '0;
      o_data      <= '0;
      o_valid     <= '0;
      o_pop_valid <= 1'b0;
    end else if (i_clear) begin
      w_ptr       <= '0;
      r_ptr       <= '0;
      count       <= '0;
      o_data      <= '0;
      o_valid     <= '0;
      o_pop_valid <= 1'b0;
    end else begin
      if (wr_acc)  w_ptr <= w_ptr + wr_n[ADDR_WIDTH-1:0];
      if (pop_acc) r_ptr <= r_ptr + pop_m[ADDR_WIDTH-1:0];
      count       <= count + (wr_acc ? wr_n : '0) - (pop_acc ? pop_m : '0);
      o_data      <= pop_acc ? pop_dat : '0;
      o_valid     <= pop_acc ? pop_vld : '0;
      o_pop_valid <= pop_acc;
    end
  end

  assign o_count = count;

endmodule

// File: doc/simo_unpack_fifo.md
# simo_unpack_fifo

Single-input, multiple-output (SIMO) FIFO that performs the reverse of the router's precision packing. It accepts one packed byte per cycle and unpacks it by precision mode into one 8-bit, two 4-bit or four 2-bit elements. Each pop returns up to DATA_LENGTH elements in parallel lanes with a per-lane valid mask. It sits on the router's return path and drives the PE-array lane inputs.

## Interface
- DEPTH, 16: element slots; power of two, ≥ DATA_LENGTH, ≥ 4
- DATA_WIDTH, 8: element and packed-word width; fixed at 8
- DATA_LENGTH, 8: output lanes per pop
- ADDR_WIDTH, $clog2(DEPTH): pointer width
- i_clk  in  1  clock; all logic on rising edge
- i_nrst  in  1  reset, synchronous, active-low
- i_clear  in  1  synchronous clear of pointers, count and outputs
- i_write_en  in  1  write request for i_data
- i_p_mode  in  2  precision mode: 00 = 8x8, 01 = 4x4, 10 = 2x2, 11 = treated as 8x8
- i_data  in  DATA_WIDTH  packed word; subword k at bits [k*w +: w]
- i_partial  in  2  0 = all subwords valid; n = 1..3 = only the low n subwords valid (clamped to mode capacity)
- i_pop_en  in  1  pop request
- o_data  out  DATA_LENGTH x DATA_WIDTH  popped elements; lane i = i-th oldest
- o_valid  out  DATA_LENGTH  per-lane valid mask
- o_pop_valid  out  1  a pop completed in the previous cycle
- o_count  out  ADDR_WIDTH+1  occupancy in elements
- o_empty  out  1  count == 0
- o_full  out  1  free slots < capacity of current i_p_mode

## Operation
- Mode capacity C: 8x8 = 1, 4x4 = 2, 2x2 = 4, 11 = 1. Subword width w = 8/C.
- Write accepted when i_write_en && !o_full.
  - n = (i_partial == 0 || i_partial ≥ C) ? C : i_partial.
  - Subword k (k < n) is written zero-extended to 8 bits at fifo[(w_pointer + k) mod DEPTH].
  - w_pointer += n, modulo DEPTH.
- Pop accepted when i_pop_en && !o_empty.
  - m = min(count, DATA_LENGTH).
  - Lanes i < m: o_data[i] = fifo[(r_pointer + i) mod DEPTH] and o_valid[i] = 1. Lanes i ≥ m: o_data[i] = 0 and o_valid[i] = 0.
  - r_pointer += m, modulo DEPTH. o_pop_valid = 1.
- Cycles without an accepted pop: o_data = 0, o_valid = 0, o_pop_valid = 0.
- count_next = count + n(accepted write) − m(accepted pop).
- o_full and o_empty are combinational from count; o_full also depends on i_p_mode.
- Pointers wrap modulo DEPTH. count distinguishes full from empty.

## Timing
- Reset (i_nrst = 0 at a rising edge): pointers and count = 0; o_data, o_valid, o_pop_valid = 0; o_empty = 1; o_full = 0. Storage contents are not reset.
- Priority: reset > i_clear > write/pop. A clear mid-operation discards all contents; write and pop requests in that cycle are ignored.
- Pop latency: 1 cycle. Outputs are registered at the edge where the pop is accepted.
- Write-to-readable latency: 1 cycle. An element written at edge t can be popped at edge t+1 at the earliest.
- Simultaneous write and pop:
  - Both are accepted.
  - m uses the pre-write count, so data written in the same cycle is not visible to that pop.
  - o_full and o_empty use the pre-update count.
- Write while o_full or pop while o_empty: ignored, no state change. An ignored pop drives o_pop_valid = 0.
- i_p_mode is sampled per write. Mixing modes between successive writes is legal.

## Test plan
- Reset: drive i_nrst = 0 for 2 cycles, then release → o_count = 0, o_empty = 1, o_full = 0, o_valid = 0, o_pop_valid = 0.
- 2x2 unpack: write 8'hE4, i_partial = 0; pop next cycle → lanes 0..3 = 00, 01, 02, 03; o_valid = 8'h0F; o_pop_valid = 1 one cycle after the pop; o_count = 0.
- 4x4 partial: write 8'hA5 with i_partial = 1, then 8'h3C with i_partial = 0; pop → lanes 0..2 = 05, 0C, 03; o_valid = 8'h07.
- Full boundary:
  - 16 writes in 8x8 mode → o_full = 1 at count 16; a 17th write is ignored; count stays 16.
  - In 2x2 mode, o_full = 1 at count 13.
- Wrap-around: write 12 bytes (8x8, values 1..12); pop → lanes = 1..8; write 13..20 → count = 12; two pops return 9..16, then 17..20 with o_valid = 8'h0F.
- Simultaneous write and pop on an empty FIFO: pop ignored (o_pop_valid = 0), count becomes 1. Asserting i_clear with count 5 and i_write_en high → count = 0 and o_empty = 1 on the next cycle.
